ram_stream_writer: RTL and testbench

- Write-side companion to the Test_RAM readout path, which drives a 6-bit DC_X sample stream out of RAM on sysclk.
- Accepts a stream of DW-bit samples over a valid/ready handshake.
- Writes each sample to consecutive RAM addresses starting at a programmable base; stops after a programmable count.
- Single sysclk domain; fills the RAM before the readout path replays it.

---
 rtl/ram_stream_writer_pkg.sv | 13 +
 rtl/ram_addr_counter.sv | 38 +++
 rtl/ram_stream_writer.sv | 126 ++++++++++++
 tb/tb_ram_stream_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_writer_pkg.sv
// Shared types and default sizes for the RAM stream writer and the readout RAM.
package ram_stream_writer_pkg;

    localparam int unsigned DEF_DW = 6;
    localparam int unsigned DEF_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_addr_counter.sv
// Loadable wrapping write pointer plus remaining-sample down-counter.
module ram_addr_counter
    import ram_stream_writer_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] load_addr,
    input  logic [AW:0]   load_count,
    output logic [AW-1:0] ptr,
    output logic          last
);

    localparam int unsigned CW = AW + 1;

    logic [AW:0] count;

    // Pointer wraps naturally at 2^AW; count holds unless a sample is taken.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (load) begin
            ptr   <= load_addr;
            count <= load_count;
        end else if (step) begin
            ptr   <= ptr + AW'(1);
            count <= count - CW'(1);
        end
    end

    // Flags the transfer that finishes the fill.
    assign last = (count == CW'(1));

endmodule

// File: rtl/ram_stream_writer.sv
// Fills consecutive RAM locations from a valid/ready sample stream.
// Optional: define RAM_WRITER_CHECKSUM_EN to add an XOR checksum output.
module ram_stream_writer
    import ram_stream_writer_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          busy,
    output logic          done
`ifdef RAM_WRITER_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_t        state_q;
    state_t        state_d;
    logic          load;
    logic          xfer;
    logic          accept_start;
    logic [AW-1:0] ptr;
    logic          last;

    ram_addr_counter #(.AW(AW)) u_cnt (
        .sysclk     (sysclk),
        .reset      (reset),
        .load       (load),
        .step       (xfer),
        .load_addr  (base_addr),
        .load_count (length),
        .ptr        (ptr),
        .last       (last)
    );

    // State register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transfer decode.
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        xfer         = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (length != '0) begin
                        load    = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (in_valid) begin
                    xfer = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is a pure decode of the state so upstream sees it in the same cycle.
    assign in_ready = (state_q == ST_WRITE);

    // Registered RAM write port and status outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ram_we <= xfer;
            if (xfer) begin
                ram_addr  <= ptr;
                ram_wdata <= in_data;
            end
            busy <= (state_d != ST_IDLE);
            done <= (state_d == ST_DONE);
        end
    end

`ifdef RAM_WRITER_CHECKSUM_EN
    // Running XOR of every accepted sample; cleared when a fill starts.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept_start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed bench for ram_stream_writer (default DW=6, AW=5).
module tb_ram_stream_writer;

    logic       sysclk;
    logic       reset;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] length;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [5:0] ram_wdata;
    logic       busy;
    logic       done;
`ifdef RAM_WRITER_CHECKSUM_EN
    logic [5:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    ram_stream_writer dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done)
`ifdef RAM_WRITER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] n);
        start     = 1'b1;
        base_addr = b;
        length    = n;
        tick();
        start     = 1'b0;
        base_addr = 5'h1f;
        length    = 6'd9;
    endtask

    // Feed n samples d0 + i*ds with gap idle cycles before each; expect writes at b+i.
    task automatic feed(input int n, input int gap, input logic [4:0] b,
                        input logic [5:0] d0, input logic [5:0] ds, input bit end_fill);
        logic [4:0] a;
        logic [5:0] d;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = 6'h3f;
                tick();
                check("stall_we", 32'(ram_we), 32'd0);
                check("stall_ready", 32'(in_ready), 32'd1);
            end
            a = b + 5'(i);
            d = d0 + 6'(i) * ds;
            in_valid = 1'b1;
            in_data  = d;
            tick();
            check("wr_we", 32'(ram_we), 32'd1);
            check("wr_addr", 32'(ram_addr), 32'(a));
            check("wr_data", 32'(ram_wdata), 32'(d));
            check("wr_done", 32'(done), 32'((end_fill && i == n - 1) ? 1 : 0));
        end
        in_valid = 1'b0;
    endtask

    // Cycle after the done pulse: back in IDLE, nothing written.
    task automatic expect_idle();
        tick();
        check("idle_we", 32'(ram_we), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        #1;
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(ram_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Basic fill 1..4 at 0..3.
        do_start(5'd0, 6'd4);
        check("basic_ready", 32'(in_ready), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        feed(4, 0, 5'd0, 6'h01, 6'h01, 1'b1);
        check("basic_ready_done", 32'(in_ready), 32'd0);
        check("basic_busy_done", 32'(busy), 32'd1);
`ifdef RAM_WRITER_CHECKSUM_EN
        check("csum_1234", 32'(checksum), 32'h04);
`endif
        in_valid = 1'b1;
        in_data  = 6'h2b;
        expect_idle();
        tick();
        check("no_consume_idle", 32'(ram_we), 32'd0);
        in_valid = 1'b0;
`ifdef RAM_WRITER_CHECKSUM_EN
        check("csum_hold", 32'(checksum), 32'h04);
`endif

        // Stalled fill at 3..5.
        do_start(5'd3, 6'd3);
        feed(3, 2, 5'd3, 6'h08, 6'h01, 1'b1);
        expect_idle();

        // Wrap 30,31,0,1.
        do_start(5'd30, 6'd4);
        feed(4, 0, 5'd30, 6'h20, 6'h01, 1'b1);
        expect_idle();

        // Full RAM from base 5 ends at 4.
        do_start(5'd5, 6'd32);
        feed(32, 0, 5'd5, 6'h00, 6'h01, 1'b1);
        expect_idle();

        // Zero length.
        do_start(5'd9, 6'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd1);
        check("zero_we", 32'(ram_we), 32'd0);
        check("zero_ready", 32'(in_ready), 32'd0);
        expect_idle();

        // start during WRITE is ignored.
        do_start(5'd10, 6'd3);
        feed(1, 0, 5'd10, 6'h11, 6'h01, 1'b0);
        start     = 1'b1;
        base_addr = 5'd20;
        length    = 6'd1;
        feed(1, 0, 5'd11, 6'h12, 6'h01, 1'b0);
        start     = 1'b0;
        feed(1, 0, 5'd12, 6'h13, 6'h01, 1'b1);
        expect_idle();

        // Reset after 2 of 5 writes.
        do_start(5'd0, 6'd5);
        feed(2, 0, 5'd0, 6'h21, 6'h01, 1'b0);
        in_valid = 1'b1;
        in_data  = 6'h23;
        #2;
        reset = 1'b1;
        #1;
        check("mrst_we", 32'(ram_we), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_we", 32'(ram_we), 32'd0);
        do_start(5'd7, 6'd2);
        feed(2, 1, 5'd7, 6'h01, 6'h01, 1'b1);
`ifdef RAM_WRITER_CHECKSUM_EN
        check("csum_12", 32'(checksum), 32'h03);
`endif
        expect_idle();

`ifdef RAM_WRITER_CHECKSUM_EN
        do_start(5'd2, 6'd3);
        check("csum_clear", 32'(checksum), 32'h00);
        feed(1, 0, 5'd2, 6'h15, 6'h15, 1'b0);
        check("csum_15", 32'(checksum), 32'h15);
        feed(2, 0, 5'd3, 6'h2a, 6'h15, 1'b1);
        check("csum_3", 32'(checksum), 32'h00);
        expect_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
